// File: rtl/vsd_ser_pkg.sv
// Framing definitions shared by the serializer and deserializer so both ends
// agree on word width, bit order and FSM encoding.
package vsd_ser_pkg;
  localparam int VSD_WIDTH = 10;

  typedef enum logic {ORDER_MSB, ORDER_LSB} bit_order_e;

  typedef enum logic {IDLE, SHIFT} vsd_state_e;
endpackage

// File: rtl/vsd_out_buf.sv
// One-deep valid/ready holding register. A new word is dropped (and overrun
// set) when it arrives while the buffer is full and not being drained.
module vsd_out_buf #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             dout_ready,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun
);
  logic drop;

  assign drop = load & dout_valid & ~dout_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (load & (~dout_valid | dout_ready)) begin
      // accept-and-reload in the same edge keeps the stream bubble-free
      dout       <= din;
      dout_valid <= 1'b1;
    end else if (~load & dout_valid & dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            overrun <= 1'b0;
    else if (drop)      overrun <= 1'b1;
    else if (clr_flags) overrun <= 1'b0;
  end
endmodule

// File: rtl/vsd_deserializer.sv
// Serial-to-parallel receiver: start-framed 1-bit stream in, WIDTH-bit words
// out through a one-deep valid/ready buffer, with overrun and frame-error flags.
module vsd_deserializer
  import vsd_ser_pkg::*;
#(
  parameter int WIDTH     = VSD_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_flags
);
  localparam int         CW    = $clog2(WIDTH);
  localparam bit_order_e ORDER = MSB_FIRST ? ORDER_MSB : ORDER_LSB;

  vsd_state_e       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] sr, sr_nxt, word, first;
  logic             complete, ferr_nxt;

  // word: shift register with this cycle's bit appended; first: a fresh frame
  always_comb begin
    if (ORDER == ORDER_MSB) begin
      word  = (sr << 1) | WIDTH'(sin);
      first = WIDTH'(sin);
    end else begin
      word  = (sr >> 1) | {sin, {(WIDTH-1){1'b0}}};
      first = {sin, {(WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    complete  = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          sr_nxt    = first;
          cnt_nxt   = CW'(1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (start) begin
          // restart wins even on the last-bit cycle: partial word discarded
          sr_nxt   = first;
          cnt_nxt  = CW'(1);
          ferr_nxt = 1'b1;
        end else if (cnt == CW'(WIDTH-1)) begin
          sr_nxt    = word;
          cnt_nxt   = '0;
          complete  = 1'b1;
          state_nxt = IDLE;
        end else begin
          sr_nxt  = word;
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sr        <= sr_nxt;
      frame_err <= ferr_nxt;
    end
  end

  vsd_out_buf #(.WIDTH(WIDTH)) u_obuf (
    .clk        (clk),
    .rst        (rst),
    .load       (complete),
    .din        (word),
    .dout_ready (dout_ready),
    .clr_flags  (clr_flags),
    .dout       (dout),
    .dout_valid (dout_valid),
    .overrun    (overrun)
  );
endmodule

// File: tb/tb_vsd_deserializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share one stimulus stream;
// expected words are queued when their last bit is driven and compared while buffered.
module tb_vsd_deserializer;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst, sin, start, rdy, clr;
  logic [W-1:0] dout_m, dout_l;
  logic         dv_m, dv_l, ovr_m, ovr_l, fe_m, fe_l;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] q[$];
  logic         exp_ovr, exp_fe, active;

  always #5 clk = ~clk;

  vsd_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .sin(sin), .start(start), .dout(dout_m), .dout_valid(dv_m),
    .dout_ready(rdy), .overrun(ovr_m), .frame_err(fe_m), .clr_flags(clr));

  vsd_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .sin(sin), .start(start), .dout(dout_l), .dout_valid(dv_l),
    .dout_ready(rdy), .overrun(ovr_l), .frame_err(fe_l), .clr_flags(clr));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h @%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = w[W-1-i];
    return r;
  endfunction

  // One clock: drive inputs, advance the model at the edge, then check outputs.
  task automatic tick(input logic st, input logic b, input logic last, input logic [W-1:0] w);
    logic acc, drop;
    start = st;
    sin   = b;
    @(posedge clk);
    if (rst) begin
      q.delete();
      exp_ovr = 1'b0;
      exp_fe  = 1'b0;
      active  = 1'b0;
    end else begin
      acc    = (q.size() != 0) && rdy;
      exp_fe = st && active;
      if (acc) void'(q.pop_front());
      drop = 1'b0;
      if (last && !st) begin
        if (q.size() == 0) q.push_back(w);
        else drop = 1'b1;
      end
      if (drop)     exp_ovr = 1'b1;
      else if (clr) exp_ovr = 1'b0;
      if (st)        active = 1'b1;
      else if (last) active = 1'b0;
    end
    #1;
    chk("valid_m", 32'(dv_m), 32'(q.size() != 0));
    chk("valid_l", 32'(dv_l), 32'(q.size() != 0));
    chk("ovr_m", 32'(ovr_m), 32'(exp_ovr));
    chk("ovr_l", 32'(ovr_l), 32'(exp_ovr));
    chk("ferr_m", 32'(fe_m), 32'(exp_fe));
    chk("ferr_l", 32'(fe_l), 32'(exp_fe));
    if (q.size() != 0) begin
      chk("dout_m", 32'(dout_m), 32'(q[0]));
      chk("dout_l", 32'(dout_l), 32'(rev(q[0])));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0);
  endtask

  // Serial bits go out first-to-last as w[W-1] .. w[0].
  task automatic send(input logic [W-1:0] w, input bit rand_rdy);
    for (int i = 0; i < W; i++) begin
      if (rand_rdy) rdy = 1'($urandom_range(0, 1));
      tick(i == 0, w[W-1-i], i == W-1, w);
    end
  endtask

  // Begin a frame that is abandoned after n bits.
  task automatic partial(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) tick(i == 0, w[W-1-i], 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1; sin = 1'b0; start = 1'b0; rdy = 1'b1; clr = 1'b0;
    q.delete(); exp_ovr = 1'b0; exp_fe = 1'b0; active = 1'b0;
    idle(3);
    chk("rst_dout_m", 32'(dout_m), 32'h0);
    chk("rst_dout_l", 32'(dout_l), 32'h0);
    rst = 1'b0;
    idle(2);

    // stream 1011001110: 0x2CE MSB-first, 0x1CD LSB-first
    chk("rev_2ce", 32'(rev(10'h2CE)), 32'h1CD);
    send(10'h2CE, 1'b0);
    chk("t1_dout_m", 32'(dout_m), 32'h2CE);
    chk("t1_dout_l", 32'(dout_l), 32'h1CD);
    idle(3);

    // back-to-back frames with the consumer stalled
    rdy = 1'b0;
    send(10'h3FF, 1'b0);
    send(10'h001, 1'b0);
    chk("t3_dout", 32'(dout_m), 32'h3FF);
    chk("t3_ovr", 32'(ovr_m), 32'h1);
    clr = 1'b1; idle(1); clr = 1'b0;
    chk("t3_clr", 32'(ovr_m), 32'h0);
    rdy = 1'b1; idle(2);

    // restart at bit 4, then restart on the last-bit cycle
    partial(10'h2F0, 4);
    send(10'h155, 1'b0);
    chk("t4_dout", 32'(dout_m), 32'h155);
    idle(2);
    partial(10'h3C3, 9);
    send(10'h0A5, 1'b0);
    chk("t4b_dout", 32'(dout_m), 32'h0A5);
    idle(2);

    // clear overrun via set/clear collision: set must win
    rdy = 1'b0;
    send(10'h111, 1'b0);
    clr = 1'b1;
    send(10'h222, 1'b0);
    clr = 1'b0;
    chk("t3b_setwin", 32'(ovr_m), 32'h1);

    // reset at bit 6 with a word buffered and overrun set
    partial(10'h3A5, 6);
    rst = 1'b1; idle(1); rst = 1'b0;
    chk("t5_dout", 32'(dout_m), 32'h0);
    chk("t5_valid", 32'(dv_m), 32'h0);
    chk("t5_ovr", 32'(ovr_m), 32'h0);
    rdy = 1'b1;
    send(10'h2AA, 1'b0);
    chk("t5_rx", 32'(dout_m), 32'h2AA);
    idle(2);

    // random loopback: random words, gaps of 0..2, random consumer stalls
    for (int f = 0; f < 40; f++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        rdy = 1'($urandom_range(0, 1));
        idle(1);
      end
      send(W'($urandom), 1'b1);
    end
    rdy = 1'b1;
    idle(3);
    chk("drain", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
